// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM state encoding,
// fetch word size and the default NOP word.
package instruction_fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } if_state_e;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register: one-cycle load of PC+4 and instruction word.
// hold_i freezes contents (decode stall); clear_i squashes to NOP and wins over hold.
module ifid_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        clear_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc4_d,   pc4_q;
    logic [31:0] instr_d, instr_q;
    logic        valid_d, valid_q;

    always_comb begin
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (clear_i) begin
            pc4_d   = 32'h0000_0000;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            pc4_d   = pc4_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc4_q   <= 32'h0000_0000;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: IDLE/RUN FSM, PC register and IF/ID register; one-cycle fetch latency.
// Stall holds PC and IF/ID, flush redirects and squashes; IF_PERF_CNT_EN adds fetch_cnt_o.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_addr_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o
`endif
);

    if_state_e   state_d, state_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] pc_plus4;
    logic        active;

    // A RUN cycle with start_i dropped already behaves as idle, so stopping never advances the PC.
    assign active   = (state_q == RUN) && start_i;
    assign pc_plus4 = pc_q + 32'(WORD_BYTES);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)  state_d = RUN;
            RUN:     if (!start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (active) begin
            if (flush_i)
                pc_d = word_align(branch_addr_i);
            else if (!stall_i)
                pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= word_align(RESET_PC);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc_o        = pc_q;
    assign imem_addr_o = pc_q;

    ifid_reg #(
        .NOP_WORD (NOP_WORD)
    ) u_ifid_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (stall_i),
        .clear_i (!active || flush_i),
        .pc4_i   (pc_plus4),
        .instr_i (imem_data_i),
        .pc4_o   (ifid_pc4_o),
        .instr_o (ifid_instr_o),
        .valid_o (ifid_valid_o)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (active && !flush_i && !stall_i)
            fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            fetch_cnt_q <= 32'h0000_0000;
        else
            fetch_cnt_q <= fetch_cnt_d;
    end

    assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed stimulus queues expected post-edge state,
// a monitor pops and compares one entry per clock edge.
module tb_instruction_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, start_a, stall_a, flush_a;
    logic [31:0] branch_a;
    logic [31:0] imem_addr_a, imem_data_a, pc_a, pc4_a, instr_a;
    logic        valid_a;

    logic        rst_b, start_b;
    logic [31:0] imem_addr_b, imem_data_b, pc_b, pc4_b, instr_b;
    logic        valid_b;

`ifdef IF_PERF_CNT_EN
    logic [31:0] cnt_a, cnt_b;
`endif

    // Memory model: word n holds n+1.
    assign imem_data_a = {2'b00, imem_addr_a[31:2]} + 32'd1;
    assign imem_data_b = {2'b00, imem_addr_b[31:2]} + 32'd1;

    instruction_fetch u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst_a),
        .start_i       (start_a),
        .stall_i       (stall_a),
        .flush_i       (flush_a),
        .branch_addr_i (branch_a),
        .imem_addr_o   (imem_addr_a),
        .imem_data_i   (imem_data_a),
        .pc_o          (pc_a),
        .ifid_pc4_o    (pc4_a),
        .ifid_instr_o  (instr_a),
        .ifid_valid_o  (valid_a)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (cnt_a)
`endif
    );

    instruction_fetch #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst_b),
        .start_i       (start_b),
        .stall_i       (1'b0),
        .flush_i       (1'b0),
        .branch_addr_i (32'h0000_0000),
        .imem_addr_o   (imem_addr_b),
        .imem_data_i   (imem_data_b),
        .pc_o          (pc_b),
        .ifid_pc4_o    (pc4_b),
        .ifid_instr_o  (instr_b),
        .ifid_valid_o  (valid_b)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt_o   (cnt_b)
`endif
    );

    typedef struct {
        int          tag;
        bit          dut_b;
        logic [3:0]  mask;   // [0] pc, [1] instr, [2] pc4, [3] valid
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check32(input int tag, input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, req);
        end
    endtask

    // Push the state expected after the next rising edge, then advance to the following falling edge.
    task automatic expect_edge(input int tag, input bit b, input logic [3:0] m,
                               input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pc4, input logic v);
        exp_t e;
        e.tag = tag; e.dut_b = b; e.mask = m;
        e.pc = pc; e.instr = instr; e.pc4 = pc4; e.valid = v;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] p, i, p4;
        logic        v;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                p  = e.dut_b ? pc_b    : pc_a;
                i  = e.dut_b ? instr_b : instr_a;
                p4 = e.dut_b ? pc4_b   : pc4_a;
                v  = e.dut_b ? valid_b : valid_a;
                if (e.mask[0]) check32(e.tag, "pc",    p,         e.pc);
                if (e.mask[1]) check32(e.tag, "instr", i,         e.instr);
                if (e.mask[2]) check32(e.tag, "pc4",   p4,        e.pc4);
                if (e.mask[3]) check32(e.tag, "valid", {31'd0,v}, {31'd0,e.valid});
            end
        end
    end

    initial begin : stimulus
        rst_a = 1'b1; start_a = 1'b0; stall_a = 1'b0; flush_a = 1'b0; branch_a = 32'h0;
        rst_b = 1'b1; start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check32(0, "rst_pc",    pc_a,             32'h0000_0000);
        check32(0, "rst_instr", instr_a,          32'h0000_0000);
        check32(0, "rst_pc4",   pc4_a,            32'h0000_0000);
        check32(0, "rst_valid", {31'd0, valid_a}, 32'd0);
        check32(0, "rst_pc_b",  pc_b,             32'hFFFF_FFF8);
`ifdef IF_PERF_CNT_EN
        check32(0, "rst_cnt",   cnt_a,            32'd0);
`endif

        // Reset then start: first edge only enters RUN.
        rst_a = 1'b0; start_a = 1'b1;
        expect_edge(1, 0, 4'hF, 32'd0,  32'd0, 32'd0,  1'b0);
        expect_edge(2, 0, 4'hF, 32'd4,  32'd1, 32'd4,  1'b1);
        expect_edge(3, 0, 4'hF, 32'd8,  32'd2, 32'd8,  1'b1);

        // Two stall cycles at pc=8.
        stall_a = 1'b1;
        expect_edge(4, 0, 4'hF, 32'd8,  32'd2, 32'd8,  1'b1);
        expect_edge(5, 0, 4'hF, 32'd8,  32'd2, 32'd8,  1'b1);
        stall_a = 1'b0;
        expect_edge(6, 0, 4'hF, 32'd12, 32'd3, 32'd12, 1'b1);
        expect_edge(7, 0, 4'hF, 32'd16, 32'd4, 32'd16, 1'b1);
`ifdef IF_PERF_CNT_EN
        check32(7, "fetch_cnt", cnt_a, 32'd4);
`endif

        // Flush with simultaneous stall, unaligned target.
        flush_a = 1'b1; stall_a = 1'b1; branch_a = 32'h0000_0043;
        expect_edge(8, 0, 4'hF, 32'h40, 32'd0,  32'd0,  1'b0);
        flush_a = 1'b0; stall_a = 1'b0;
        expect_edge(9, 0, 4'hF, 32'h44, 32'h11, 32'h44, 1'b1);

        // Redirect to pc=12 for the mid-run reset.
        flush_a = 1'b1; branch_a = 32'h0000_000D;
        expect_edge(10, 0, 4'hF, 32'd12, 32'd0, 32'd0, 1'b0);
        flush_a = 1'b0;

        rst_a = 1'b1;
        #1;
        check32(11, "arst_pc",    pc_a,             32'd0);
        check32(11, "arst_valid", {31'd0, valid_a}, 32'd0);
        check32(11, "arst_instr", instr_a,          32'd0);
        check32(11, "arst_pc4",   pc4_a,            32'd0);
        @(negedge clk);

        // After reset, no fetching until start_i is seen.
        rst_a = 1'b0; start_a = 1'b0;
        expect_edge(12, 0, 4'hF, 32'd0, 32'd0, 32'd0, 1'b0);
        start_a = 1'b1;
        expect_edge(13, 0, 4'hF, 32'd0, 32'd0, 32'd0, 1'b0);
        expect_edge(14, 0, 4'hF, 32'd4, 32'd1, 32'd4, 1'b1);

        // Stop: PC holds and valid drops; flush/stall ignored while idle.
        start_a = 1'b0;
        expect_edge(15, 0, 4'hB, 32'd4, 32'd0, 32'd0, 1'b0);
        flush_a = 1'b1; stall_a = 1'b1; branch_a = 32'h0000_0080;
        expect_edge(16, 0, 4'hB, 32'd4, 32'd0, 32'd0, 1'b0);
        flush_a = 1'b0; stall_a = 1'b0;

        // PC wrap on the second instance.
        rst_b = 1'b0; start_b = 1'b1;
        expect_edge(17, 1, 4'hF, 32'hFFFF_FFF8, 32'd0,         32'd0,         1'b0);
        expect_edge(18, 1, 4'hF, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 1'b1);
        expect_edge(19, 1, 4'hF, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
